// File: rtl/ctrl_unit_stack.sv
// ctrl_unit_stack: fetch/execute sequencer with a 16-entry register file,
// ALU operand steering, PC control with a hardware return-address stack,
// a ready-based SRAM handshake, multi-port GPIO and a sticky fault state.
module ctrl_unit_stack #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 12,
  parameter int MEM_AW      = 6,
  parameter int STACK_DEPTH = 4,
  parameter int N_PORTS     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_valid,
  input  logic [15:0]                 instruction,
  input  logic [PC_W-1:0]             pc_cur,
  input  logic [DATA_W-1:0]           alu_result,
  input  logic                        equal,
  input  logic                        carry_out,
  input  logic                        bootstrapping,
  input  logic [N_PORTS*DATA_W-1:0]   in_gpio,
  input  logic                        mem_ready,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [2:0]                  alu_opcode,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [MEM_AW-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        pc_load,
  output logic [PC_W-1:0]             pc_next,
  output logic                        pc_inc,
  output logic [N_PORTS*DATA_W-1:0]   out_gpio,
  output logic [1:0]                  state,
  output logic                        fault
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int EXT_W = (PC_W > 12) ? PC_W : 12;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_EXECUTE  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  state_t                      r_state;
  logic [3:0]                  r_op;
  logic [3:0]                  r_rd;
  logic [3:0]                  r_ra;
  logic [3:0]                  r_rb;
  logic [3:0]                  r_port;
  logic [DATA_W-1:0]           r_port_in;
  logic [DATA_W-1:0]           r_regs [16];
  logic [PC_W-1:0]             r_stack [STACK_DEPTH];
  logic [SP_W-1:0]             r_sp;
  logic [2:0]                  r_alu_opcode;
  logic [DATA_W-1:0]           r_alu_a;
  logic [DATA_W-1:0]           r_alu_b;
  logic                        r_mem_req;
  logic                        r_mem_we;
  logic [MEM_AW-1:0]           r_mem_addr;
  logic [DATA_W-1:0]           r_mem_wdata;
  logic                        r_pc_load;
  logic [PC_W-1:0]             r_pc_next;
  logic [N_PORTS*DATA_W-1:0]   r_gpio;
  logic                        r_fault;

  logic [3:0]                  w_fetch_port;
  logic [DATA_W-1:0]           w_fetch_port_data;
  logic [PC_W-1:0]             w_stack_top;
  logic                        w_stack_full;
  logic                        w_stack_empty;
  logic [EXT_W-1:0]            w_jmp_ext;
  logic [EXT_W-1:0]            w_call_ext;
  logic [DATA_W-1:0]           w_in_value;

  // Select the GPIO input port addressed by the instruction being fetched.
  always_comb begin
    w_fetch_port      = 4'(int'(instruction[3:0]) % N_PORTS);
    w_fetch_port_data = {DATA_W{1'b0}};
    for (int p = 0; p < N_PORTS; p++) begin
      w_fetch_port_data = w_fetch_port_data |
        ((w_fetch_port == 4'(p)) ? in_gpio[p*DATA_W +: DATA_W] : {DATA_W{1'b0}});
    end
  end

  // Return-stack status, top-of-stack value and decoded branch targets.
  always_comb begin
    w_stack_full  = (r_sp == SP_W'(STACK_DEPTH));
    w_stack_empty = (r_sp == {SP_W{1'b0}});
    w_stack_top   = {PC_W{1'b0}};
    for (int i = 0; i < STACK_DEPTH; i++) begin
      w_stack_top = w_stack_top |
        ((r_sp == SP_W'(i + 1)) ? r_stack[i] : {PC_W{1'b0}});
    end
    w_jmp_ext  = EXT_W'({r_rd, r_ra, r_rb});
    w_call_ext = EXT_W'({r_rd[2:0], r_ra, r_rb});
    if (bootstrapping) begin
      w_in_value = DATA_W'({r_ra, r_rb});
    end else begin
      w_in_value = r_port_in;
    end
  end

  // Sequencer FSM with register file, return stack, GPIO and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FETCH;
      r_op         <= 4'd0;
      r_rd         <= 4'd0;
      r_ra         <= 4'd0;
      r_rb         <= 4'd0;
      r_port       <= 4'd0;
      r_port_in    <= {DATA_W{1'b0}};
      for (int i = 0; i < 16; i++) r_regs[i] <= {DATA_W{1'b0}};
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= {PC_W{1'b0}};
      r_sp         <= {SP_W{1'b0}};
      r_alu_opcode <= 3'd0;
      r_alu_a      <= {DATA_W{1'b0}};
      r_alu_b      <= {DATA_W{1'b0}};
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {MEM_AW{1'b0}};
      r_mem_wdata  <= {DATA_W{1'b0}};
      r_pc_load    <= 1'b0;
      r_pc_next    <= {PC_W{1'b0}};
      r_gpio       <= {(N_PORTS*DATA_W){1'b0}};
      r_fault      <= 1'b0;
    end else if (clk_valid) begin
      case (r_state)
        ST_FETCH: begin
          r_op         <= instruction[15:12];
          r_rd         <= instruction[11:8];
          r_ra         <= instruction[7:4];
          r_rb         <= instruction[3:0];
          r_port       <= w_fetch_port;
          r_port_in    <= w_fetch_port_data;
          r_alu_a      <= r_regs[instruction[7:4]];
          r_alu_b      <= r_regs[instruction[3:0]];
          r_alu_opcode <= instruction[14:12];
          r_mem_addr   <= instruction[MEM_AW-1:0];
          r_mem_wdata  <= r_regs[instruction[11:8]];
          r_pc_load    <= 1'b0;
          r_state      <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          r_pc_load <= 1'b0;
          r_state   <= ST_FETCH;
          case (r_op)
            4'd0: begin
            end
            4'd1: begin
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
              r_state   <= ST_MEM_WAIT;
            end
            4'd2: begin
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b1;
              r_state   <= ST_MEM_WAIT;
            end
            4'd3: begin
              r_pc_next <= w_jmp_ext[PC_W-1:0];
              r_pc_load <= 1'b1;
            end
            4'd4: begin
              if (equal) begin
                r_pc_next <= w_jmp_ext[PC_W-1:0];
                r_pc_load <= 1'b1;
              end
            end
            4'd5: begin
              if (carry_out) begin
                r_pc_next <= w_jmp_ext[PC_W-1:0];
                r_pc_load <= 1'b1;
              end
            end
            4'd6: r_regs[r_rd] <= w_in_value;
            4'd7: begin
              for (int p = 0; p < N_PORTS; p++) begin
                if (r_port == 4'(p)) r_gpio[p*DATA_W +: DATA_W] <= r_regs[r_rd];
              end
            end
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14: begin
              r_regs[r_rd] <= alu_result;
            end
            4'd15: begin
              if (!r_rd[3]) begin
                // CALL: a push into a full stack would lose a return address.
                if (w_stack_full) begin
                  r_state <= ST_FAULT;
                  r_fault <= 1'b1;
                end else begin
                  for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (r_sp == SP_W'(i)) r_stack[i] <= pc_cur;
                  end
                  r_sp      <= r_sp + SP_W'(1);
                  r_pc_next <= w_call_ext[PC_W-1:0];
                  r_pc_load <= 1'b1;
                end
              end else begin
                // RET: popping an empty stack has no valid target.
                if (w_stack_empty) begin
                  r_state <= ST_FAULT;
                  r_fault <= 1'b1;
                end else begin
                  r_sp      <= r_sp - SP_W'(1);
                  r_pc_next <= w_stack_top;
                  r_pc_load <= 1'b1;
                end
              end
            end
            default: begin
            end
          endcase
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            if (r_op == 4'd1) r_regs[r_rd] <= mem_rdata;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= ST_FETCH;
          end
        end
        ST_FAULT: begin
          r_fault <= 1'b1;
          r_state <= ST_FAULT;
        end
        default: begin
          r_state <= ST_FAULT;
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign pc_load    = r_pc_load;
  assign pc_next    = r_pc_next;
  assign pc_inc     = (r_state == ST_FETCH) & clk_valid;
  assign out_gpio   = r_gpio;
  assign state      = r_state;
  assign fault      = r_fault;

endmodule

// File: tb/tb_ctrl_unit_stack.sv
// Self-checking bench for ctrl_unit_stack: directed scenarios plus random
// instructions, checked against an instruction-level model of the machine.
module tb_ctrl_unit_stack;

  localparam int DW = 8;
  localparam int PW = 12;
  localparam int AW = 6;
  localparam int SD = 4;
  localparam int NP = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_valid;
  logic [15:0]       instruction;
  logic [PW-1:0]     pc_cur;
  logic [DW-1:0]     alu_result;
  logic              equal;
  logic              carry_out;
  logic              bootstrapping;
  logic [NP*DW-1:0]  in_gpio;
  logic              mem_ready;
  logic [DW-1:0]     mem_rdata;
  logic [2:0]        alu_opcode;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              pc_load;
  logic [PW-1:0]     pc_next;
  logic              pc_inc;
  logic [NP*DW-1:0]  out_gpio;
  logic [1:0]        state;
  logic              fault;

  int n_tests = 0;
  int n_fail  = 0;

  // Instruction-level model of the architectural state.
  logic [7:0]  m_regs [16];
  logic [7:0]  m_gpio [NP];
  logic [11:0] m_stk [$];
  logic [11:0] m_pc_next;
  logic        m_fault;

  logic [15:0] r_ins;
  int          cyc;

  ctrl_unit_stack #(
    .DATA_W(DW), .PC_W(PW), .MEM_AW(AW), .STACK_DEPTH(SD), .N_PORTS(NP)
  ) dut (
    .clk(clk), .rst(rst), .clk_valid(clk_valid), .instruction(instruction),
    .pc_cur(pc_cur), .alu_result(alu_result), .equal(equal),
    .carry_out(carry_out), .bootstrapping(bootstrapping), .in_gpio(in_gpio),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc_load(pc_load),
    .pc_next(pc_next), .pc_inc(pc_inc), .out_gpio(out_gpio), .state(state),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gpio_exp();
    logic [31:0] v;
    v = 32'd0;
    for (int p = 0; p < NP; p++) v[p*8 +: 8] = m_gpio[p];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    for (int p = 0; p < NP; p++) m_gpio[p] = 8'h00;
    m_stk.delete();
    m_pc_next = 12'h000;
    m_fault   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},    32'(state),      32'd0);
    check({tag, "_fault"},    32'(fault),      32'd0);
    check({tag, "_mem_req"},  32'(mem_req),    32'd0);
    check({tag, "_mem_we"},   32'(mem_we),     32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr),   32'd0);
    check({tag, "_wdata"},    32'(mem_wdata),  32'd0);
    check({tag, "_alu_a"},    32'(alu_a),      32'd0);
    check({tag, "_alu_b"},    32'(alu_b),      32'd0);
    check({tag, "_alu_op"},   32'(alu_opcode), 32'd0);
    check({tag, "_pc_load"},  32'(pc_load),    32'd0);
    check({tag, "_pc_next"},  32'(pc_next),    32'd0);
    check({tag, "_gpio"},     out_gpio,        32'd0);
  endtask

  // Run one instruction from FETCH to completion and compare with the model.
  // *_sel < 0 picks a random value for that input.
  task automatic exec(input logic [15:0] ins, input logic [11:0] pc, input int waits,
                      input int boot_sel, input int alu_sel, input int rdata_sel);
    logic [3:0] op, rd, ra, rb;
    int         port, exp_state, req_cycles;
    logic       exp_load;
    op = ins[15:12]; rd = ins[11:8]; ra = ins[7:4]; rb = ins[3:0];
    port          = int'(rb) % NP;
    instruction   = ins;
    pc_cur        = pc;
    alu_result    = (alu_sel < 0) ? 8'($urandom) : 8'(alu_sel);
    bootstrapping = (boot_sel < 0) ? 1'($urandom) : 1'(boot_sel);
    mem_rdata     = (rdata_sel < 0) ? 8'($urandom) : 8'(rdata_sel);
    equal         = 1'($urandom);
    carry_out     = 1'($urandom);
    in_gpio       = $urandom;
    mem_ready     = 1'b0;
    clk_valid     = 1'b1;
    check("fetch_state", 32'(state), 32'd0);
    check("fetch_pc_inc", 32'(pc_inc), 32'd1);
    step();
    check("exec_state", 32'(state), 32'd1);
    check("exec_pc_load", 32'(pc_load), 32'd0);
    check("exec_alu_a", 32'(alu_a), 32'(m_regs[ra]));
    check("exec_alu_b", 32'(alu_b), 32'(m_regs[rb]));
    check("exec_alu_op", 32'(alu_opcode), 32'(ins[14:12]));
    check("exec_mem_addr", 32'(mem_addr), 32'(ins[5:0]));
    check("exec_wdata", 32'(mem_wdata), 32'(m_regs[rd]));
    step();
    exp_state = 0;
    exp_load  = 1'b0;
    case (op)
      4'd1, 4'd2: begin
        req_cycles = 0;
        check("mem_state", 32'(state), 32'd2);
        check("mem_we", 32'(mem_we), 32'(op == 4'd2));
        check("mem_wait_addr", 32'(mem_addr), 32'(ins[5:0]));
        check("mem_wait_wdata", 32'(mem_wdata), 32'(m_regs[rd]));
        if (mem_req) req_cycles++;
        for (int i = 0; i < waits; i++) begin
          step();
          if (mem_req) req_cycles++;
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("mem_req_cycles", 32'(req_cycles), 32'(waits + 1));
        if (op == 4'd1) m_regs[rd] = mem_rdata;
      end
      4'd3: begin
        m_pc_next = ins[11:0];
        exp_load  = 1'b1;
      end
      4'd4: begin
        if (equal) begin
          m_pc_next = ins[11:0];
          exp_load  = 1'b1;
        end
      end
      4'd5: begin
        if (carry_out) begin
          m_pc_next = ins[11:0];
          exp_load  = 1'b1;
        end
      end
      4'd6: m_regs[rd] = bootstrapping ? {ra, rb} : in_gpio[port*8 +: 8];
      4'd7: m_gpio[port] = m_regs[rd];
      4'd15: begin
        if (!rd[3]) begin
          if (m_stk.size() == SD) begin
            exp_state = 3; m_fault = 1'b1;
          end else begin
            m_stk.push_back(pc);
            m_pc_next = {1'b0, ins[10:0]};
            exp_load  = 1'b1;
          end
        end else begin
          if (m_stk.size() == 0) begin
            exp_state = 3; m_fault = 1'b1;
          end else begin
            m_pc_next = m_stk.pop_back();
            exp_load  = 1'b1;
          end
        end
      end
      4'd0: begin
      end
      default: m_regs[rd] = alu_result;
    endcase
    check("end_state", 32'(state), 32'(exp_state));
    check("end_pc_load", 32'(pc_load), 32'(exp_load));
    check("end_pc_next", 32'(pc_next), 32'(m_pc_next));
    check("end_gpio", out_gpio, gpio_exp());
    check("end_fault", 32'(fault), 32'(m_fault));
    check("end_mem_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1; clk_valid = 1'b1; instruction = 16'h0000; pc_cur = 12'h000;
    alu_result = 8'h00; equal = 1'b0; carry_out = 1'b0; bootstrapping = 1'b0;
    in_gpio = 32'h0; mem_ready = 1'b0; mem_rdata = 8'h00;
    model_reset();
    step(); step();
    rst = 1'b0;
    check_reset_outputs("por");

    // ALU path: R1=5, R2=3 via IN, R3=alu_result, then OUT to port 0.
    exec(16'h6105, 12'h001, 0, 1, -1, -1);
    exec(16'h6203, 12'h002, 0, 1, -1, -1);
    exec(16'h8312, 12'h003, 0, -1, 8, -1);
    exec(16'h7300, 12'h004, 0, -1, -1, -1);
    check("alu_out_port0", 32'(out_gpio[7:0]), 32'h08);

    // LOAD with three wait states, then STORE of the loaded register.
    exec(16'h142A, 12'h005, 3, -1, -1, 8'h5C);
    exec(16'h2415, 12'h006, 1, -1, -1, -1);
    check("store_wdata", 32'(mem_wdata), 32'h5C);

    // OUT rd=1 rb=6 updates only port 2.
    exec(16'h7106, 12'h007, 0, -1, -1, -1);
    check("gpio_port2", out_gpio, 32'h0005_0008);

    // clk_valid low for three cycles mid-instruction stretches a NOP to 5 cycles.
    instruction = 16'h0000;
    cyc = 0;
    step(); cyc++;
    clk_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); cyc++;
      check("freeze_hold", 32'(state), 32'd1);
    end
    clk_valid = 1'b1;
    while (state != 2'd0 && cyc < 20) begin
      step(); cyc++;
    end
    check("freeze_latency", 32'(cyc), 32'd5);

    // mem_ready while frozen in MEM_WAIT is ignored.
    instruction = 16'h1700; mem_ready = 1'b0;
    step(); step();
    check("frz_mem_state", 32'(state), 32'd2);
    clk_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 8'h33;
    step(); step();
    check("frz_mem_hold", 32'(state), 32'd2);
    check("frz_mem_req", 32'(mem_req), 32'd1);
    clk_valid = 1'b1;
    step();
    mem_ready = 1'b0;
    check("frz_mem_done", 32'(state), 32'd0);
    m_regs[7] = 8'h33;
    exec(16'h0077, 12'h008, 0, -1, -1, -1);

    // CALL / RET, then nesting to full depth with LIFO returns.
    exec(16'hF123, 12'h010, 0, -1, -1, -1);
    check("call_target", 32'(pc_next), 32'h123);
    exec(16'hF800, 12'h050, 0, -1, -1, -1);
    check("ret_target", 32'(pc_next), 32'h010);
    for (int k = 1; k <= SD; k++) exec(16'hF000 | 16'(k * 17), 12'(k * 16), 0, -1, -1, -1);
    for (int k = SD; k >= 1; k--) begin
      exec(16'hF800, 12'h0FF, 0, -1, -1, -1);
      check("ret_lifo", 32'(pc_next), 32'(k * 16));
    end

    // Random instruction stream; CALL/RET steered away from faults.
    for (int k = 0; k < 60; k++) begin
      r_ins = 16'($urandom);
      if (r_ins[15:12] == 4'hF) begin
        if (m_stk.size() == SD) r_ins[11] = 1'b1;
        else if (m_stk.size() == 0) r_ins[11] = 1'b0;
      end
      exec(r_ins, 12'($urandom), int'($urandom_range(0, 3)), -1, -1, -1);
    end

    // Reset in MEM_WAIT drops mem_req and suppresses the write-back.
    instruction = 16'h1400; mem_ready = 1'b0; clk_valid = 1'b1;
    step(); step();
    check("rst_pre_req", 32'(mem_req), 32'd1);
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 8'hFF;
    step(); step();
    rst = 1'b0; mem_ready = 1'b0;
    model_reset();
    check_reset_outputs("rst_mid");
    exec(16'h0044, 12'h001, 0, -1, -1, -1);

    // RET on empty stack faults; the fault state is sticky and inert.
    exec(16'hF800, 12'h002, 0, -1, -1, -1);
    instruction = 16'h7100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fault_sticky", 32'(state), 32'd3);
      check("fault_pc_inc", 32'(pc_inc), 32'd0);
      check("fault_gpio", out_gpio, gpio_exp());
    end
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    check_reset_outputs("rst_fault");

    // Fifth nested CALL overflows the 4-entry stack.
    for (int k = 1; k <= SD + 1; k++) exec(16'hF000 | 16'(k * 3), 12'(k * 32), 0, -1, -1, -1);
    check("ovf_state", 32'(state), 32'd3);
    check("ovf_fault", 32'(fault), 32'd1);
    check("ovf_no_load", 32'(pc_load), 32'd0);
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    check_reset_outputs("rst_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_unit_stack.md
# ctrl_unit_stack

Parametrised successor of the 8-bit microcontroller control unit: fetch/execute sequencer with internal register file, ALU operand steering, PC control and GPIO. Adds configurable data width, a hardware return-address stack (CALL/RET), a ready-based SRAM handshake with wait states, multi-port GPIO and a sticky fault state. Sits between program memory/PC, ALU, data SRAM and GPIO pads.

## Interface
Parameters:
- DATA_W, 8, datapath/register width (≥8)
- PC_W, 12, program-counter width (≥11)
- MEM_AW, 6, SRAM address width (≤8)
- STACK_DEPTH, 4, return-stack entries (≥1)
- N_PORTS, 2, GPIO port count (1..16)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clk_valid  in  1  cycle enable; when low, all state holds
- instruction  in  16  current instruction word
- pc_cur  in  PC_W  PC value (already incremented during FETCH)
- alu_result  in  DATA_W  ALU result
- equal, carry_out  in  1 each  ALU flags
- bootstrapping  in  1  IN loads immediate instead of port
- in_gpio  in  N_PORTS*DATA_W  input ports, port p at [p*DATA_W +: DATA_W]
- mem_ready  in  1  SRAM completes request this cycle
- mem_rdata  in  DATA_W  SRAM read data, valid with mem_ready
- alu_opcode  out  3; alu_a, alu_b  out  DATA_W
- mem_req  out  1; mem_we  out  1; mem_addr  out  MEM_AW; mem_wdata  out  DATA_W
- pc_load  out  1  one-cycle load pulse; pc_next  out  PC_W
- pc_inc  out  1  = (state==FETCH) & clk_valid
- out_gpio  out  N_PORTS*DATA_W  registered output ports
- state  out  2  FETCH=0, EXECUTE=1, MEM_WAIT=2, FAULT=3
- fault  out  1  sticky stack fault

## Operation
- Fields: op=[15:12], rd=[11:8], ra=[7:4], rb=[3:0]; imm12=[11:0]; port = rb mod N_PORTS.
- FETCH: latch fields, alu_a=R[ra], alu_b=R[rb], alu_opcode=op[2:0], mem_addr=instruction[MEM_AW-1:0], mem_wdata=R[rd], sample in_gpio; → EXECUTE.
- EXECUTE (pc_load cleared first; actions below override):
  - 0 NOP. 1 LOAD: mem_req=1, mem_we=0 → MEM_WAIT. 2 STORE: mem_req=1, mem_we=1 → MEM_WAIT.
  - 3 JMP: pc_next=imm12 zero-extended, pc_load=1. 4 BEQ / 5 BC: same, only if equal / carry_out.
  - 6 IN: R[rd] = bootstrapping ? {ra,rb} zero-extended : sampled port.
  - 7 OUT: out_gpio[port] = R[rd].
  - 8..14 ALU: R[rd] = alu_result.
  - 15, rd[3]=0 CALL: if stack full → FAULT; else push pc_cur, pc_next={rd[2:0],ra,rb} zero-extended, pc_load=1.
  - 15, rd[3]=1 RET: if stack empty → FAULT; else pop, pc_next=popped value, pc_load=1.
  - Otherwise → FETCH.
- MEM_WAIT: hold mem_req/mem_we/addr/data; on mem_ready: LOAD writes R[rd]=mem_rdata, deassert mem_req → FETCH. No timeout.
- FAULT: fault=1, pc_inc=0, no register/GPIO/memory changes; exit only by rst.
- Stack: LIFO, count 0..STACK_DEPTH; push at full or pop at empty are faults, never wrap.

## Timing
- All outputs registered except pc_inc. Every transition/update requires clk_valid=1; clk_valid=0 freezes everything, including a pending mem_ready (ignored).
- Reset (rst high at clk edge, overrides clk_valid): state=FETCH, all R=0, stack count=0, out_gpio=0, pc_load=0, pc_next=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, alu_a/alu_b/alu_opcode=0, fault=0. Reset mid-MEM_WAIT drops mem_req next cycle, no write-back.
- Non-memory instruction: 2 enabled cycles. Memory: 3 + N cycles, N = enabled cycles mem_ready stays low in MEM_WAIT; mem_req visible the cycle after EXECUTE edge.
- pc_load high exactly one enabled cycle, during the following FETCH; pc_next stable until next load.
- mem_ready while mem_req=0 ignored.

## Test plan
- Reset: drive rst 2 cycles mid-execution → all outputs 0, state=0, fault=0.
- ALU: R1=5, R2=3 via IN bootstrapping, then op 8 rd=3 ra=1 rb=2 with alu_result=8 → R3=8, observable by OUT rd=3 port 0 → out_gpio[7:0]=8.
- LOAD wait states: LOAD R4,addr 0x2A, mem_ready low 3 cycles then high with rdata 0x5C → mem_req high 4 cycles, mem_addr=0x2A, R4=0x5C; STORE variant asserts mem_we with mem_wdata=R[rd].
- CALL/RET: pc_cur=0x010, CALL 0x123 → pc_load pulse, pc_next=0x123; later RET → pc_next=0x010; nested to depth 4 returns in LIFO order.
- Faults: 5th nested CALL with STACK_DEPTH=4 → state=3, fault=1, no pc_load; RET on empty stack after reset → same.
- GPIO/enable: N_PORTS=4, OUT rd=1 rb=6 → only port 2 updates; toggling clk_valid low for 3 cycles mid-instruction extends latency by exactly 3 cycles.
